// File: rtl/dmem_responder.sv
// Handshaked data-memory target: captures one request, waits WAIT_STATES cycles, then acks.
// Define DMEM_BYTE_EN for byte-lane stores and byte-enable legality checking.
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_in,
    input  logic        write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  be_in,
    output logic        busy_out,
    output logic        ack_out,
    output logic [31:0] rdata_out,
    output logic        err_out
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        r_state, w_state_nxt;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_cap;
    logic          w_enter_resp;
    logic          w_write;
    logic [31:0]   w_addr;
    logic [AW-1:0] w_idx;
    logic          w_be_bad;
    logic          w_err;

`ifdef DMEM_BYTE_EN
    logic [3:0]    r_be;
    logic [3:0]    w_be;
`else
    logic          w_unused_be;
    assign w_unused_be = ^be_in;
`endif

    // On the capture edge the live inputs are used so a zero-wait access resolves immediately.
    always_comb begin
        w_cap    = (r_state == StIdle) && req_in;
        w_write  = w_cap ? write_in : r_write;
        w_addr   = w_cap ? addr_in : r_addr;
        w_idx    = w_addr[AW+1:2];
        w_be_bad = 1'b0;
`ifdef DMEM_BYTE_EN
        w_be = w_cap ? be_in : r_be;
        if (w_write) begin
            case (w_be)
                4'b0000, 4'b0001, 4'b0010, 4'b0100,
                4'b1000, 4'b0011, 4'b1100, 4'b1111: w_be_bad = 1'b0;
                default:                            w_be_bad = 1'b1;
            endcase
        end
`endif
        w_err = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH)) || w_be_bad;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (req_in) w_state_nxt = (WAIT_STATES == 0) ? StResp : StWait;
            StWait:  if (r_cnt <= 4'd1) w_state_nxt = StResp;
            StResp:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        w_enter_resp = (w_state_nxt == StResp) && (r_state != StResp);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
`ifdef DMEM_BYTE_EN
            r_be    <= 4'h0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_cap) begin
                r_write <= write_in;
                r_addr  <= addr_in;
                r_wdata <= wdata_in;
                r_cnt   <= 4'(WAIT_STATES);
`ifdef DMEM_BYTE_EN
                r_be    <= be_in;
`endif
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_err <= w_enter_resp && w_err;
            if (w_enter_resp && !w_write && !w_err) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Storage is not reset; a store commits only on the RESP->IDLE edge, so reset aborts it.
    always_ff @(posedge clk) begin
        if ((r_state == StResp) && r_write && !r_err) begin
`ifdef DMEM_BYTE_EN
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) r_mem[r_addr[AW+1:2]][8*i +: 8] <= r_wdata[8*i +: 8];
            end
`else
            r_mem[r_addr[AW+1:2]] <= r_wdata;
`endif
        end
    end

    assign busy_out  = (r_state != StIdle);
    assign ack_out   = (r_state == StResp);
    assign err_out   = r_err;
    assign rdata_out = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a zero-wait instance (dut0) and a two-wait instance (dut1).
module tb_dmem_responder;
    localparam int unsigned DEPTH = 256;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        busy  [2];
    logic        ack   [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_in(req[0]), .write_in(wr[0]), .addr_in(addr[0]),
        .wdata_in(wdata[0]), .be_in(be[0]), .busy_out(busy[0]), .ack_out(ack[0]),
        .rdata_out(rdata[0]), .err_out(err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut1 (
        .clk(clk), .reset(reset), .req_in(req[1]), .write_in(wr[1]), .addr_in(addr[1]),
        .wdata_in(wdata[1]), .be_in(be[1]), .busy_out(busy[1]), .ack_out(ack[1]),
        .rdata_out(rdata[1]), .err_out(err[1])
    );

    function automatic int ws_of(input int p);
        return (p == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int p);
        exp_t e;
        int   n;
        n = (p == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected ack: got ack with empty scoreboard, expected none", p);
        end else begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("dut%0d err", p), {31'b0, err[p]}, {31'b0, e.err});
            chk($sformatf("dut%0d rdata", p), rdata[p], e.rdata);
            chk($sformatf("dut%0d ack cycle", p), 32'(cyc), 32'(e.cyc));
            chk($sformatf("dut%0d busy at ack", p), {31'b0, busy[p]}, 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (ack[0] === 1'b1) mon(0);
        if (ack[1] === 1'b1) mon(1);
    end

    // Called at a negedge; b2b means the DUT is in its ack cycle right now.
    task automatic txn(input int p, input bit b2b, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic e,
                       input logic [31:0] rd, input bit scramble);
        exp_t x;
        bit   seen;
        seen     = 1'b0;
        req[p]   = 1'b1;
        wr[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        be[p]    = b;
        x.err    = e;
        x.rdata  = rd;
        x.cyc    = cyc + (b2b ? 2 : 1) + ws_of(p);
        if (p == 0) q0.push_back(x);
        else        q1.push_back(x);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (b2b && i == 0) chk($sformatf("dut%0d idle gap busy", p), {31'b0, busy[p]}, 32'd0);
            if (scramble && i == 0) begin
                addr[p]  = a ^ 32'h4;
                wdata[p] = ~d;
            end
            if (ack[p] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL dut%0d ack timeout: got no ack in 40 cycles, expected ack for %h", p, a);
        end
    endtask

    task automatic gap(input int p);
        req[p] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; wr[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0; be[p] = 4'hF;
        end
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("dut%0d reset ack", p),   {31'b0, ack[p]},  32'd0);
            chk($sformatf("dut%0d reset err", p),   {31'b0, err[p]},  32'd0);
            chk($sformatf("dut%0d reset busy", p),  {31'b0, busy[p]}, 32'd0);
            chk($sformatf("dut%0d reset rdata", p), rdata[p],         32'h0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Two wait states: store then load.
        txn(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);        gap(1);
        txn(1, 0, 0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, 0);        gap(1);

        // Zero wait states: back-to-back stores then loads with req held.
        txn(0, 0, 1, 32'h0, 32'hA0A0A0A0, 4'hF, 0, 32'h0, 0);
        txn(0, 1, 1, 32'h4, 32'hB1B1B1B1, 4'hF, 0, 32'h0, 0);
        txn(0, 1, 1, 32'h8, 32'hC2C2C2C2, 4'hF, 0, 32'h0, 0);
        txn(0, 1, 0, 32'h0, 32'h0, 4'hF, 0, 32'hA0A0A0A0, 0);
        txn(0, 1, 0, 32'h4, 32'h0, 4'hF, 0, 32'hB1B1B1B1, 0);
        txn(0, 1, 0, 32'h8, 32'h0, 4'hF, 0, 32'hC2C2C2C2, 0);
        gap(0);

        // Errors: misaligned load, out-of-range store aliasing word 0; last valid word.
        txn(1, 0, 0, 32'h12, 32'h0, 4'hF, 1, 32'hDEADBEEF, 0);          gap(1);
        txn(1, 0, 1, 32'h0, 32'h01020304, 4'hF, 0, 32'hDEADBEEF, 0);    gap(1);
        txn(1, 0, 1, 32'h100, 32'h600DF00D, 4'hF, 0, 32'hDEADBEEF, 0);  gap(1);
        txn(1, 0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 1, 32'hDEADBEEF, 0);  gap(1);
        txn(1, 0, 0, 32'h0, 32'h0, 4'hF, 0, 32'h01020304, 0);           gap(1);
        txn(1, 0, 0, 32'h100, 32'h0, 4'hF, 0, 32'h600DF00D, 0);         gap(1);
        txn(1, 0, 1, 32'h3FC, 32'h77778888, 4'hF, 0, 32'h600DF00D, 0);  gap(1);
        txn(1, 0, 0, 32'h3FC, 32'h0, 4'hF, 0, 32'h77778888, 0);         gap(1);

        // Reset during WAIT aborts the second store.
        txn(1, 0, 1, 32'h20, 32'h11111111, 4'hF, 0, 32'h77778888, 0);  gap(1);
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h22222222; be[1] = 4'hF;
        @(negedge clk);
        chk("dut1 busy in wait", {31'b0, busy[1]}, 32'd1);
        reset = 1'b0;
        #1;
        chk("dut1 mid-reset ack",   {31'b0, ack[1]},  32'd0);
        chk("dut1 mid-reset err",   {31'b0, err[1]},  32'd0);
        chk("dut1 mid-reset busy",  {31'b0, busy[1]}, 32'd0);
        chk("dut1 mid-reset rdata", rdata[1],         32'h0);
        @(negedge clk);
        req[1] = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        txn(1, 0, 0, 32'h20, 32'h0, 4'hF, 0, 32'h11111111, 0);          gap(1);

        // Inputs changed during WAIT must not affect the captured access.
        txn(1, 0, 1, 32'h44, 32'h55555555, 4'hF, 0, 32'h11111111, 0);  gap(1);
        txn(1, 0, 1, 32'h40, 32'h12345678, 4'hF, 0, 32'h11111111, 1);  gap(1);
        txn(1, 0, 0, 32'h44, 32'h0, 4'hF, 0, 32'h55555555, 0);          gap(1);
        txn(1, 0, 0, 32'h40, 32'h0, 4'hF, 0, 32'h12345678, 0);          gap(1);

`ifdef DMEM_BYTE_EN
        txn(1, 0, 1, 32'h30, 32'hAABBCCDD, 4'b1111, 0, 32'h12345678, 0); gap(1);
        txn(1, 0, 1, 32'h30, 32'h00EE0000, 4'b0100, 0, 32'h12345678, 0); gap(1);
        txn(1, 0, 0, 32'h30, 32'h0, 4'hF, 0, 32'hAAEECCDD, 0);            gap(1);
        txn(1, 0, 1, 32'h30, 32'h11111111, 4'b0101, 1, 32'hAAEECCDD, 0); gap(1);
        txn(1, 0, 0, 32'h30, 32'h0, 4'hF, 0, 32'hAAEECCDD, 0);            gap(1);
`endif

        repeat (5) @(negedge clk);
        chk("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
        chk("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder: the target-side end of the processor's data-memory read/write interface.
- Accepts one load/store request at a time, inserts a configurable number of wait states, then performs the access and returns a single-cycle acknowledge with read data or an error flag.
- Sits between the datapath's memory-access stage (multi-cycle / stall-capable core) and a word-organised storage array; replaces the zero-latency data memory.

Parameters:
- DEPTH, 256, number of 32-bit words in the storage array (power of two, 4..4096).
- WAIT_STATES, 2, extra cycles between request capture and acknowledge (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_in  input  1  request valid; held high by initiator until ack_out seen.
- write_in  input  1  1 = store, 0 = load; stable while req_in high.
- addr_in  input  32  byte address; stable while req_in high.
- wdata_in  input  32  store data; stable while req_in high.
- be_in  input  4  byte enables, bit i = byte lane i (ignored unless DMEM_BYTE_EN).
- busy_out  output  1  high when not IDLE.
- ack_out  output  1  one-cycle completion strobe.
- rdata_out  output  32  load data; valid in ack cycle, held until next load ack.
- err_out  output  1  valid with ack_out; access rejected.

Behaviour:
- Reset (reset low, async): state=IDLE, wait counter=0, ack_out=0, err_out=0, busy_out=0, rdata_out=32'h0, captured request regs cleared. Storage array contents NOT cleared. Reset mid-transaction aborts it; a pending store is never written.
- States: IDLE, WAIT, RESP.
- IDLE: on req_in=1 capture write_in, addr_in, wdata_in, be_in; load counter with WAIT_STATES; go WAIT if WAIT_STATES>0, else RESP.
- WAIT: decrement counter each cycle; when counter reaches 1 go RESP. Input changes ignored (captured copy used).
- RESP: ack_out=1 for exactly this cycle; access performed at this clock edge; next state IDLE.
- Latency: request sampled in IDLE at edge N -> ack_out high during cycle N+1+WAIT_STATES.
- Error check (in RESP): err_out=1 if captured addr[1:0]!=0 or word index addr[31:2] >= DEPTH. On error: no write, rdata_out unchanged, ack_out still asserted.
- Load, no error: rdata_out <= mem[addr[31:2]], visible in ack cycle (registered in RESP entry edge).
- Store, no error: mem[addr[31:2]] <= wdata at the RESP->IDLE edge; rdata_out unchanged.
- ack_out and err_out are 0 outside RESP.
- Back-to-back: req_in high in IDLE cycle after ack starts a new transaction; minimum spacing between acks = WAIT_STATES+2 cycles.
- req_in dropping during WAIT/RESP is a protocol violation; transaction still completes.
- Store then load to same address: load returns the stored value.

Optional Feature:
- Macro DMEM_BYTE_EN: stores write only lanes with be_in[i]=1; be_in=4'b0000 completes with ack and no write; err_out also raised if be_in is not one of 0001/0010/0100/1000/0011/1100/1111 (or 0000).
- Without DMEM_BYTE_EN: be_in ignored; every store writes the full word.

Test Plan:
- WAIT_STATES=2, store addr 0x10 data 0xDEADBEEF, then load 0x10 -> each ack 3 cycles after capture; rdata_out=0xDEADBEEF, err_out=0.
- WAIT_STATES=0, back-to-back loads 0x0, 0x4, 0x8 with req held -> ack every 2nd cycle, correct data per word, busy_out toggles.
- Misaligned load 0x12 and out-of-range store 0x400 (DEPTH=256) -> ack with err_out=1; mem[0x100>>2] unaffected; rdata_out holds prior value.
- Store 0x20=0x11111111, assert reset low during WAIT of store 0x20=0x22222222, release, load 0x20 -> 0x11111111; outputs 0 during reset.
- DMEM_BYTE_EN: word 0x30=0xAABBCCDD, store be=0100 data 0x00EE0000, load -> 0xAAEECCDD; store be=0101 -> err_out=1, no write.
- Captured inputs: change addr_in/wdata_in during WAIT -> access uses values sampled at capture.
